// File: rtl/cube_motion_if.sv
// Player-cube bus: frame tick, buttons, floor positions in; cube position and status out.
interface cube_motion_if;
  logic       clk_vga;
  logic       btn_jump;
  logic       btn_left;
  logic       btn_right;
  logic [9:0] floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3;
  logic [9:0] floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3;
  logic [3:0] enable;
  logic [9:0] cube_x;
  logic [9:0] cube_y;
  logic [8:0] time_gap;
  logic       hit_ceiling;
  logic       landed;
  logic       game_over;

  // Driver side: debouncers, floor_gen and the frame tick source.
  modport master (
    output clk_vga, btn_jump, btn_left, btn_right,
    output floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    output floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    output enable,
    input  cube_x, cube_y, time_gap, hit_ceiling, landed, game_over
  );

  // Cube physics side.
  modport slave (
    input  clk_vga, btn_jump, btn_left, btn_right,
    input  floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
    input  floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
    input  enable,
    output cube_x, cube_y, time_gap, hit_ceiling, landed, game_over
  );
endinterface

// File: rtl/cube_motion.sv
// Player-cube physics: jump/rise/fall/horizontal motion per frame tick,
// landing on floors from floor_gen and off-screen death detection.

// Per-floor geometry check. All math in 11 bits so floor edges near 0 and
// sums above 1023 never wrap; the left-edge test is rearranged to avoid
// a negative x_i - FLOOR_HALF_W.
module cube_floor_chk #(
  parameter int CUBE_SIZE    = 20,
  parameter int FLOOR_HALF_W = 40
) (
  input  logic        en,
  input  logic [9:0]  fx,
  input  logic [9:0]  fy,
  input  logic [9:0]  cx,
  input  logic [10:0] bottom,
  input  logic        step,
  output logic        support,
  output logic        land
);
  logic [10:0] fx_w, fy_w, cx_w;
  logic        overlap;

  assign fx_w = {1'b0, fx};
  assign fy_w = {1'b0, fy};
  assign cx_w = {1'b0, cx};

  // cube_x + CUBE_SIZE > fx - HALF_W  <=>  cube_x + CUBE_SIZE + HALF_W > fx
  assign overlap = (cx_w + 11'(CUBE_SIZE + FLOOR_HALF_W) > fx_w) &&
                   (cx_w <= fx_w + 11'(FLOOR_HALF_W));

  assign support = en && overlap && (bottom == fy_w);
  assign land    = en && overlap && (bottom <= fy_w) &&
                   (bottom + {10'd0, step} >= fy_w);
endmodule

module cube_motion #(
  parameter int CUBE_SIZE    = 20,
  parameter int FLOOR_HALF_W = 40,
  parameter int CEIL_Y       = 40,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int START_X      = 140,
  parameter int START_Y      = 200,
  parameter int RISE_END     = 320
) (
  input  logic         clk,
  input  logic         rst,
  cube_motion_if.slave bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {ST_STAND, ST_RISE, ST_FALL, ST_DEAD} state_t;

  state_t     state, state_nxt;
  logic [9:0] cube_x, x_nxt;
  logic [9:0] cube_y, y_nxt;
  logic [8:0] time_gap, tg_nxt;
  logic [8:0] fall_cnt, fc_nxt;
  logic [1:0] floor_idx, fidx_nxt;
  logic       jump_req, jump_req_nxt;
  logic       btn_prev;

  logic [NUM_LANES-1:0][9:0] fx, fy;
  logic [NUM_LANES-1:0]      support, land;
  logic [1:0]                land_idx;
  logic [10:0]               bottom, y_fall;
  logic                      rs, fs, btn_rise, mv_l, mv_r;

  // Rise schedule, shared with floor_gen: decelerates in four 80-step bands.
  function automatic logic rise_step(input logic [8:0] n);
    if      (n < 9'd80)  return 1'b1;
    else if (n < 9'd160) return n[0] == 1'b0;
    else if (n < 9'd240) return n[1:0] == 2'b00;
    else if (n < 9'd320) return n[2:0] == 3'b000;
    else                 return 1'b0;
  endfunction

  // Fall schedule: the rise schedule mirrored, accelerating to 1 px/tick.
  function automatic logic fall_step(input logic [8:0] n);
    if      (n < 9'd80)  return n[2:0] == 3'b000;
    else if (n < 9'd160) return n[1:0] == 2'b00;
    else if (n < 9'd240) return n[0] == 1'b0;
    else                 return 1'b1;
  endfunction

  assign fx = {bus.floor_pos_x3, bus.floor_pos_x2, bus.floor_pos_x1, bus.floor_pos_x0};
  assign fy = {bus.floor_pos_y3, bus.floor_pos_y2, bus.floor_pos_y1, bus.floor_pos_y0};

  assign rs       = rise_step(time_gap);
  assign fs       = fall_step(fall_cnt);
  assign bottom   = {1'b0, cube_y} + 11'(CUBE_SIZE);
  assign y_fall   = {1'b0, cube_y} + {10'd0, fs};
  assign btn_rise = bus.btn_jump & ~btn_prev;
  assign mv_l     = bus.btn_left & ~bus.btn_right;
  assign mv_r     = bus.btn_right & ~bus.btn_left;

  // One geometry checker per floor slot; all use the pre-move cube_x.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cube_floor_chk #(
      .CUBE_SIZE    (CUBE_SIZE),
      .FLOOR_HALF_W (FLOOR_HALF_W)
    ) u_chk (
      .en      (bus.enable[g]),
      .fx      (fx[g]),
      .fy      (fy[g]),
      .cx      (cube_x),
      .bottom  (bottom),
      .step    (fs),
      .support (support[g]),
      .land    (land[g])
    );
  end

  // Lowest-index qualifying floor wins the landing.
  always_comb begin
    land_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (land[i]) land_idx = 2'(i);
  end

  // State register: async reset to the start position, falling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FALL;
      cube_x    <= 10'(START_X);
      cube_y    <= 10'(START_Y);
      time_gap  <= '0;
      fall_cnt  <= '0;
      floor_idx <= '0;
      jump_req  <= 1'b0;
      btn_prev  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cube_x    <= x_nxt;
      cube_y    <= y_nxt;
      time_gap  <= tg_nxt;
      fall_cnt  <= fc_nxt;
      floor_idx <= fidx_nxt;
      jump_req  <= jump_req_nxt;
      btn_prev  <= bus.btn_jump;
    end
  end

  // Next-state: everything moves only on a frame tick, and never once dead.
  always_comb begin
    state_nxt    = state;
    x_nxt        = cube_x;
    y_nxt        = cube_y;
    tg_nxt       = time_gap;
    fc_nxt       = fall_cnt;
    fidx_nxt     = floor_idx;
    jump_req_nxt = (state == ST_DEAD) ? jump_req : (jump_req | btn_rise);

    if (bus.clk_vga && state != ST_DEAD) begin
      // Request is consumed on every tick; an edge on the tick itself is kept.
      jump_req_nxt = btn_rise;

      if (mv_l && cube_x != 10'd0)
        x_nxt = cube_x - 10'd1;
      else if (mv_r && {1'b0, cube_x} < 11'(SCREEN_W - CUBE_SIZE))
        x_nxt = cube_x + 10'd1;

      unique case (state)
        ST_STAND: begin
          if (jump_req) begin
            state_nxt = ST_RISE;
            tg_nxt    = 9'd1;
          end else if (!support[floor_idx]) begin
            state_nxt = ST_FALL;
            fc_nxt    = '0;
          end else begin
            y_nxt = fy[floor_idx] - 10'(CUBE_SIZE);
          end
        end
        ST_RISE: begin
          if (time_gap == 9'(RISE_END)) begin
            state_nxt = ST_FALL;
            tg_nxt    = '0;
            fc_nxt    = '0;
          end else begin
            tg_nxt = time_gap + 9'd1;
            if ({1'b0, cube_y} < 11'(CEIL_Y) + {10'd0, rs})
              y_nxt = 10'(CEIL_Y);
            else
              y_nxt = cube_y - {9'd0, rs};
          end
        end
        ST_FALL: begin
          fc_nxt = (fall_cnt == 9'h1FF) ? fall_cnt : fall_cnt + 9'd1;
          if (|land) begin
            state_nxt = ST_STAND;
            fidx_nxt  = land_idx;
            y_nxt     = fy[land_idx] - 10'(CUBE_SIZE);
          end else begin
            y_nxt = y_fall[9:0];
            if (y_fall + 11'(CUBE_SIZE) >= 11'(SCREEN_H))
              state_nxt = ST_DEAD;
          end
        end
        ST_DEAD: ;
      endcase
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    bus.cube_x      = cube_x;
    bus.cube_y      = cube_y;
    bus.time_gap    = time_gap;
    bus.landed      = (state == ST_STAND);
    bus.game_over   = (state == ST_DEAD);
    bus.hit_ceiling = (state == ST_RISE) && (cube_y == 10'(CEIL_Y));
  end
endmodule
